// File: rtl/if_stage_ctrl_if.sv
// Fetch-stage bus: hazard/branch controls and imem data in; fetch PC, IF/ID contents, bubble and debug counters out.
// Latency: none (signal bundle only).
// Backpressure: hazard_detected is the only hold-off; it freezes the stage for as long as it is high.
interface if_stage_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 hazard_detected;
  logic                 branch_taken;
  logic [31:0]          branch_addr;
  logic [31:0]          instr_in;
  logic [31:0]          pc_out;
  logic [31:0]          if_id_pc;
  logic [31:0]          if_id_instr;
  logic                 bubble_to_exe;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] flush_count;
  logic                 stall_timeout;

  // Upstream side: hazard unit, branch resolver and instruction memory.
  modport master (
    output hazard_detected, branch_taken, branch_addr, instr_in,
    input  pc_out, if_id_pc, if_id_instr, bubble_to_exe,
           stall_cycles, flush_count, stall_timeout
  );

  // The fetch stage itself.
  modport slave (
    input  hazard_detected, branch_taken, branch_addr, instr_in,
    output pc_out, if_id_pc, if_id_instr, bubble_to_exe,
           stall_cycles, flush_count, stall_timeout
  );
endinterface

// File: rtl/if_stage_ctrl.sv
// Instruction fetch: PC register, IF/ID register, hazard freeze, taken-branch flush, stall/flush stats, stall watchdog.
// Latency: fetched instruction reaches IF/ID one edge after its PC is presented; a taken branch costs one bubble.
// Backpressure: hazard_detected holds PC and IF/ID and overrides any branch; bubble_to_exe follows it combinationally.
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 16,
  parameter int          MAX_STALL = 4
) (
  input logic             clk,
  input logic             rst,
  if_stage_ctrl_if.slave  bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [3:0]           STALL_LIM = 4'(MAX_STALL);

  logic [31:0]          pc_q;
  logic [31:0]          if_id_pc_q;
  logic [31:0]          if_id_instr_q;
  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] flush_q;
  logic [3:0]           run_q;
  logic                 timeout_q;

  logic                 freeze;
  logic                 flush;
  logic [31:0]          pc_plus4;

  // A branch compared against a pending source is not trustworthy, so hazard masks it.
  assign freeze   = bus.hazard_detected;
  assign flush    = bus.branch_taken & ~bus.hazard_detected;
  assign pc_plus4 = pc_q + 32'd4;

  assign bus.pc_out        = pc_q;
  assign bus.if_id_pc      = if_id_pc_q;
  assign bus.if_id_instr   = if_id_instr_q;
  assign bus.bubble_to_exe = bus.hazard_detected;
  assign bus.stall_cycles  = stall_q;
  assign bus.flush_count   = flush_q;
  assign bus.stall_timeout = timeout_q;

  // PC and IF/ID advance, hold on freeze, or redirect to the target with a NOP in ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= 32'h0;
    end else if (freeze) begin
      pc_q          <= pc_q;
      if_id_pc_q    <= if_id_pc_q;
      if_id_instr_q <= if_id_instr_q;
    end else if (flush) begin
      pc_q          <= bus.branch_addr;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= 32'h0;
    end else begin
      pc_q          <= pc_plus4;
      if_id_pc_q    <= pc_plus4;
      if_id_instr_q <= bus.instr_in;
    end
  end

  // Saturating debug statistics plus a sticky watchdog on long consecutive stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q   <= '0;
      flush_q   <= '0;
      run_q     <= 4'd0;
      timeout_q <= 1'b0;
    end else begin
      if (freeze && stall_q != CNT_MAX) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush && flush_q != CNT_MAX) begin
        flush_q <= flush_q + 1'b1;
      end
      if (!freeze) begin
        run_q <= 4'd0;
      end else if (run_q != 4'hF) begin
        run_q <= run_q + 4'd1;
      end
      // run_q counts stalls already taken, so equality marks the (MAX_STALL+1)-th one.
      if (freeze && run_q == STALL_LIM) begin
        timeout_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_if_stage_ctrl.sv
module tb_if_stage_ctrl;
  localparam int          CW     = 4;
  localparam int          MAXS   = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          CMAX   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   const_instr = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  if_stage_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  if_stage_ctrl #(
    .RESET_PC (RST_PC),
    .CNT_WIDTH(CW),
    .MAX_STALL(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (const_instr) return 32'h1111_1111;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // Combinational instruction memory addressed by the fetch PC.
  assign bus.instr_in = imem(bus.pc_out);

  // Reference state, tracked as plain integers and a run length.
  logic [31:0] m_pc, m_ifpc, m_ifinstr;
  int          m_stall, m_flush, m_run;
  bit          m_to;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit h, input bit b, input logic [31:0] a);
    logic [31:0] ins;
    ins = imem(m_pc);
    if (r) begin
      m_pc = RST_PC; m_ifpc = 0; m_ifinstr = 0;
      m_stall = 0; m_flush = 0; m_run = 0; m_to = 0;
      return;
    end
    if (h) begin
      if (m_run >= MAXS) m_to = 1;
      m_run++;
      m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
    end else begin
      m_run = 0;
      if (b) begin
        m_flush = (m_flush + 1 > CMAX) ? CMAX : m_flush + 1;
        m_pc = a; m_ifpc = 0; m_ifinstr = 0;
      end else begin
        m_ifpc = m_pc + 32'd4;
        m_ifinstr = ins;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit h, input bit b, input logic [31:0] a);
    @(negedge clk);
    rst = r;
    bus.hazard_detected = h;
    bus.branch_taken = b;
    bus.branch_addr = a;
    #1;
    chk("bubble", {31'b0, bus.bubble_to_exe}, {31'b0, h});
    model_step(r, h, b, a);
    @(posedge clk);
    #1;
    chk("pc_out", bus.pc_out, m_pc);
    chk("if_id_pc", bus.if_id_pc, m_ifpc);
    chk("if_id_instr", bus.if_id_instr, m_ifinstr);
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stall));
    chk("flush_count", 32'(bus.flush_count), 32'(m_flush));
    chk("stall_timeout", {31'b0, bus.stall_timeout}, {31'b0, m_to});
  endtask

  initial begin
    bus.hazard_detected = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr = 32'h0;

    // Reset and free-running fetch of a constant instruction.
    cycle(1, 0, 0, 0);
    chk("rst_pc", bus.pc_out, RST_PC);
    repeat (3) cycle(0, 0, 0, 0);
    chk("free_pc", bus.pc_out, 32'd12);
    chk("free_ifpc", bus.if_id_pc, 32'd12);
    chk("free_instr", bus.if_id_instr, 32'h1111_1111);

    // Two-cycle freeze at pc 8.
    const_instr = 1'b0;
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);
    chk("pre_stall_pc", bus.pc_out, 32'd8);
    repeat (2) cycle(0, 1, 0, 0);
    chk("stall_hold_pc", bus.pc_out, 32'd8);
    chk("stall_count2", 32'(bus.stall_cycles), 32'd2);
    cycle(0, 0, 0, 0);
    chk("release_pc", bus.pc_out, 32'd12);

    // Taken branch at pc 16.
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h100);
    chk("br_pc", bus.pc_out, 32'h100);
    chk("br_flush1", 32'(bus.flush_count), 32'd1);
    cycle(0, 0, 0, 0);
    chk("br_target_ifpc", bus.if_id_pc, 32'h104);

    // Hazard masks a simultaneous branch; branch taken once hazard clears.
    cycle(0, 1, 1, 32'h200);
    chk("mask_flush", 32'(bus.flush_count), 32'd1);
    cycle(0, 0, 1, 32'h200);
    chk("late_br_pc", bus.pc_out, 32'h200);

    // Watchdog fires on the fifth consecutive stall and is sticky until reset.
    repeat (4) cycle(0, 1, 0, 0);
    chk("wd_not_yet", {31'b0, bus.stall_timeout}, 32'd0);
    cycle(0, 1, 0, 0);
    chk("wd_fire", {31'b0, bus.stall_timeout}, 32'd1);
    repeat (2) cycle(0, 0, 0, 0);
    chk("wd_sticky", {31'b0, bus.stall_timeout}, 32'd1);
    cycle(1, 1, 1, 32'h300);
    chk("wd_clear", {31'b0, bus.stall_timeout}, 32'd0);
    chk("rst_stall0", 32'(bus.stall_cycles), 32'd0);

    // Statistics saturate; PC wraps past the top of the address space.
    repeat (20) cycle(0, 1, 0, 0);
    chk("stall_sat", 32'(bus.stall_cycles), 32'(CMAX));
    cycle(0, 0, 1, 32'hFFFF_FFF8);
    cycle(0, 0, 0, 0);
    chk("pre_wrap", bus.pc_out, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0);
    chk("wrap_pc", bus.pc_out, 32'h0);

    // Random mix of hazards, branches and occasional resets.
    for (int i = 0; i < 600; i++) begin
      bit r, h, b;
      logic [31:0] a;
      r = ($urandom_range(99) < 2);
      h = ($urandom_range(99) < ((i % 100) < 30 ? 80 : 25));
      b = ($urandom_range(99) < 20);
      a = {$urandom, 2'b00} ;
      if ($urandom_range(9) == 0) a = 32'hFFFF_FFF4;
      cycle(r, h, b, a);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
